// File: rtl/fe_fetch_q.sv
// Front-end fetch controller: pipelined block fetch into an instruction queue,
// with mispredict/nuke redirects and epoch-tagged dropping of stale fills.
module fe_fetch_q #(
  parameter int unsigned FETCH_W         = 2,
  parameter int unsigned IQ_DEPTH        = 8,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PADDR_W         = 32,
  parameter int unsigned ROBID_W         = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [PADDR_W-1:0]                 boot_pc,
  input  logic                               nuke_valid,
  input  logic                               resume_fetch,
  input  logic [ROBID_W-1:0]                 oldest_robid,
  input  logic                               mispred_valid,
  input  logic [ROBID_W-1:0]                 mispred_robid,
  input  logic [PADDR_W-1:0]                 mispred_pc,
  output logic                               req_valid,
  output logic [PADDR_W-1:0]                 req_addr,
  output logic [$clog2(MAX_OUTSTANDING)-1:0] req_id,
  input  logic                               req_ready,
  input  logic                               rsp_valid,
  input  logic [$clog2(MAX_OUTSTANDING)-1:0] rsp_id,
  input  logic [32*FETCH_W-1:0]              rsp_instr,
  output logic                               dec_valid,
  output logic [31:0]                        dec_instr,
  output logic [PADDR_W-1:0]                 dec_pc,
  input  logic                               dec_ready
);
  localparam int unsigned OFF_W  = $clog2(FETCH_W*4);
  localparam int unsigned SLOT_W = $clog2(FETCH_W);
  localparam int unsigned IQ_AW  = $clog2(IQ_DEPTH);
  localparam int unsigned TAG_W  = $clog2(MAX_OUTSTANDING);
  localparam int unsigned EP_W   = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned BASE_W = PADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PDG_NUKE} state_e;

  state_e               state_q, state_d;
  logic [PADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [EP_W-1:0]      epoch_q, epoch_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [TAG_W-1:0]     req_tag_q, req_tag_d;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
  logic [IQ_AW:0]       wr_ptr_q, wr_ptr_d;
  logic [IQ_AW:0]       rd_ptr_q, rd_ptr_d;
  logic                 pend_q, pend_d;
  logic [ROBID_W-1:0]   pend_robid_q, pend_robid_d;

  logic [EP_W-1:0]      tag_epoch_q [MAX_OUTSTANDING];
  logic [SLOT_W-1:0]    tag_slot_q  [MAX_OUTSTANDING];
  logic [BASE_W-1:0]    tag_base_q  [MAX_OUTSTANDING];
  logic [31:0]          iq_instr_q  [IQ_DEPTH];
  logic [PADDR_W-1:0]   iq_pc_q     [IQ_DEPTH];

  logic [ROBID_W-1:0]   age_new, age_pend;
  logic                 mp_qual, redirect, fire, pop, rsp_keep;
  logic                 iq_empty, iq_full, credit_ok;
  logic [IQ_AW:0]       iq_count, enq_n;
  logic [SLOT_W-1:0]    rsp_slot;
  logic [BASE_W-1:0]    rsp_base;
  logic [IQ_AW-1:0]     slot_idx [FETCH_W];
  logic [PADDR_W-1:0]   slot_pc  [FETCH_W];
  logic                 slot_en  [FETCH_W];

  // Ages are distances from the oldest ROB entry, so wrapped ids compare correctly.
  assign age_new  = mispred_robid - oldest_robid;
  assign age_pend = pend_robid_q - oldest_robid;
  assign mp_qual  = mispred_valid && (!pend_q || (age_new < age_pend));
  assign redirect = mp_qual || nuke_valid;

  assign iq_count = wr_ptr_q - rd_ptr_q;
  assign iq_empty = (wr_ptr_q == rd_ptr_q);
  assign iq_full  = (wr_ptr_q[IQ_AW-1:0] == rd_ptr_q[IQ_AW-1:0]) &&
                    (wr_ptr_q[IQ_AW] != rd_ptr_q[IQ_AW]);
  // Every in-flight block reserves FETCH_W entries, so a return can never overflow.
  assign credit_ok = (32'(IQ_DEPTH) - 32'(iq_count)) >=
                     (32'(FETCH_W) * (32'(inflight_q) + 32'd1));

  assign req_valid = (state_q == S_FETCH) && (inflight_q < MAX_CNT) && credit_ok && !redirect;
  assign req_addr  = {fetch_pc_q[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_id    = req_tag_q;
  assign fire      = req_valid && req_ready;

  assign rsp_slot  = tag_slot_q[rsp_tag_q];
  assign rsp_base  = tag_base_q[rsp_tag_q];
  assign rsp_keep  = rsp_valid && (tag_epoch_q[rsp_tag_q] == epoch_q) && !redirect;
  assign enq_n     = (IQ_AW+1)'(FETCH_W) - (IQ_AW+1)'(rsp_slot);

  assign dec_valid = !iq_empty && (state_q != S_PDG_NUKE);
  assign dec_instr = dec_valid ? iq_instr_q[rd_ptr_q[IQ_AW-1:0]] : '0;
  assign dec_pc    = dec_valid ? iq_pc_q[rd_ptr_q[IQ_AW-1:0]] : '0;
  assign pop       = dec_valid && dec_ready;

  always_comb begin
    for (int unsigned s = 0; s < FETCH_W; s++) begin
      slot_idx[s] = wr_ptr_q[IQ_AW-1:0] + IQ_AW'(s) - IQ_AW'(rsp_slot);
      slot_pc[s]  = {rsp_base, SLOT_W'(s), 2'b00};
      slot_en[s]  = rsp_keep && (SLOT_W'(s) >= rsp_slot);
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    epoch_d      = epoch_q;
    inflight_d   = inflight_q + CNT_W'(fire) - CNT_W'(rsp_valid);
    req_tag_d    = req_tag_q + TAG_W'(fire);
    rsp_tag_d    = rsp_tag_q + TAG_W'(rsp_valid);
    wr_ptr_d     = rsp_keep ? (wr_ptr_q + enq_n) : wr_ptr_q;
    rd_ptr_d     = rd_ptr_q + (IQ_AW+1)'(pop);
    pend_d       = pend_q;
    pend_robid_d = pend_robid_q;

    unique case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (nuke_valid) state_d = S_PDG_NUKE;
      S_PDG_NUKE: if (resume_fetch) state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase

    if (mp_qual) begin
      fetch_pc_d   = mispred_pc;
      pend_d       = 1'b1;
      pend_robid_d = mispred_robid;
    end else if (fire) begin
      fetch_pc_d = req_addr + PADDR_W'(FETCH_W*4);
    end
    if (nuke_valid) pend_d = 1'b0;

    // Flush by collapsing the read pointer; in-flight blocks stay counted and
    // are discarded on return by the epoch mismatch.
    if (redirect) begin
      epoch_d  = epoch_q + EP_W'(1);
      rd_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= boot_pc;
      epoch_q      <= '0;
      inflight_q   <= '0;
      req_tag_q    <= '0;
      rsp_tag_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_q       <= 1'b0;
      pend_robid_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      epoch_q      <= epoch_d;
      inflight_q   <= inflight_d;
      req_tag_q    <= req_tag_d;
      rsp_tag_q    <= rsp_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_q       <= pend_d;
      pend_robid_q <= pend_robid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      tag_epoch_q[req_tag_q] <= epoch_q;
      tag_slot_q[req_tag_q]  <= fetch_pc_q[OFF_W-1:2];
      tag_base_q[req_tag_q]  <= fetch_pc_q[PADDR_W-1:OFF_W];
    end
    for (int unsigned s = 0; s < FETCH_W; s++) begin
      if (slot_en[s]) begin
        iq_instr_q[slot_idx[s]] <= rsp_instr[32*s +: 32];
        iq_pc_q[slot_idx[s]]    <= slot_pc[s];
      end
    end
  end

  rsp_id_match: assert property (@(posedge clk) disable iff (reset)
    rsp_valid |-> (rsp_id == rsp_tag_q));
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    rsp_keep |-> (!iq_full && ((32'(iq_count) + 32'(enq_n)) <= IQ_DEPTH)));
  no_underflow: assert property (@(posedge clk) disable iff (reset)
    rsp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fe_fetch_q.sv
// Bench for fe_fetch_q: in-order fill-buffer model plus a PC scoreboard on the decode port.
`timescale 1ns/1ps
module tb_fe_fetch_q;
  localparam int unsigned FW = 2, DEPTH = 8, MO = 2, PW = 32, RW = 6;
  localparam int unsigned TW = $clog2(MO);

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [PW-1:0]   boot_pc = '0;
  logic            nuke_valid = 1'b0, resume_fetch = 1'b0;
  logic [RW-1:0]   oldest_robid = '0;
  logic            mispred_valid = 1'b0;
  logic [RW-1:0]   mispred_robid = '0;
  logic [PW-1:0]   mispred_pc = '0;
  logic            req_valid;
  logic [PW-1:0]   req_addr;
  logic [TW-1:0]   req_id;
  logic            req_ready = 1'b1;
  logic            rsp_valid = 1'b0;
  logic [TW-1:0]   rsp_id = '0;
  logic [32*FW-1:0] rsp_instr = '0;
  logic            dec_valid;
  logic [31:0]     dec_instr;
  logic [PW-1:0]   dec_pc;
  logic            dec_ready = 1'b0;

  always #5 clk = ~clk;

  fe_fetch_q #(.FETCH_W(FW), .IQ_DEPTH(DEPTH), .MAX_OUTSTANDING(MO),
               .PADDR_W(PW), .ROBID_W(RW)) dut (
    .clk(clk), .reset(reset), .boot_pc(boot_pc),
    .nuke_valid(nuke_valid), .resume_fetch(resume_fetch), .oldest_robid(oldest_robid),
    .mispred_valid(mispred_valid), .mispred_robid(mispred_robid), .mispred_pc(mispred_pc),
    .req_valid(req_valid), .req_addr(req_addr), .req_id(req_id), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_instr(rsp_instr),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready));

  int passed = 0, total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  // Fill-buffer model: fixed latency, one response per cycle, in request order.
  typedef struct { logic [PW-1:0] addr; logic [TW-1:0] id; int due; } freq_t;
  freq_t fq[$];
  int cyc = 0, lat = 2, max_out = 0;
  bit rr_rand = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && req_valid && req_ready) begin
        fq.push_back('{req_addr, req_id, cyc + lat});
        if (fq.size() > max_out) max_out = fq.size();
      end
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      req_ready = rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (reset) fq.delete();
      else if (fq.size() > 0 && fq[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_id = fq[0].id;
        for (int s = 0; s < FW; s++) rsp_instr[32*s +: 32] = mem_word(fq[0].addr + 32'(4*s));
        void'(fq.pop_front());
      end
    end
  end

  // Scoreboard on the decode handshake.
  logic [PW-1:0] sb_q[$];
  int n_hs = 0;
  always @(negedge clk) begin
    if (!reset && dec_valid && dec_ready) begin
      n_hs++;
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL dec_extra: got delivery of pc 0x%0h, expected none", dec_pc);
      end else begin
        logic [PW-1:0] e;
        e = sb_q.pop_front();
        check("dec_pc", dec_pc, e);
        check("dec_instr", dec_instr, mem_word(e));
      end
    end
  end

  task automatic push_seq(input logic [PW-1:0] start, input int n);
    for (int k = 0; k < n; k++) sb_q.push_back(start + 32'(4*k));
  endtask

  task automatic do_reset(input logic [PW-1:0] pc);
    #2;
    boot_pc = pc;
    reset = 1'b1;
    dec_ready = 1'b0; mispred_valid = 1'b0; nuke_valid = 1'b0; resume_fetch = 1'b0;
    sb_q.delete();
    #1;
    check("rst_req_valid", req_valid, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_dec_pc", dec_pc, 0);
    check("rst_dec_instr", dec_instr, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    @(posedge clk); #1;
    dec_ready = 1'b1;
    for (int i = 0; i < budget && sb_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    dec_ready = 1'b0;
    check("drain_remaining", sb_q.size(), 0);
  endtask

  task automatic mispredict(input logic [RW-1:0] rob, input logic [PW-1:0] pc);
    @(posedge clk); #1;
    mispred_valid = 1'b1; mispred_robid = rob; mispred_pc = pc;
  endtask

  typedef struct {
    logic [PW-1:0] boot; logic [PW-1:0] exp_req; logic [PW-1:0] exp_first;
    int n; int lat; int bp; int burst; bit rrand;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   h0;
    bit   got, seen_req, seen_dec;
    vecs[0] = '{32'h1000, 32'h1000, 32'h1000, 24, 1, 0,  0, 1'b0};
    vecs[1] = '{32'h1004, 32'h1000, 32'h1004, 15, 3, 0,  0, 1'b1};
    vecs[2] = '{32'h2008, 32'h2008, 32'h2008, 20, 2, 20, 8, 1'b0};
    vecs[3] = '{32'h300C, 32'h3008, 32'h300C, 11, 4, 20, 7, 1'b0};
    oldest_robid = 6'd2;

    for (int v = 0; v < 4; v++) begin
      lat = vecs[v].lat;
      rr_rand = vecs[v].rrand;
      do_reset(vecs[v].boot);
      push_seq(vecs[v].exp_first, vecs[v].n);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (req_valid) got = 1;
      end
      check("first_req_seen", got, 1);
      check("first_req_addr", req_addr, vecs[v].exp_req);
      if (vecs[v].bp > 0) begin
        repeat (vecs[v].bp) @(posedge clk);
        @(negedge clk);
        check("bp_req_stalled", req_valid, 0);
        check("bp_dec_valid", dec_valid, 1);
        check("bp_head_pc", dec_pc, vecs[v].exp_first);
        @(posedge clk); #1;
        dec_ready = 1'b1;
        h0 = n_hs;
        repeat (vecs[v].burst) @(posedge clk);
        #1;
        check("bp_burst_len", n_hs - h0, vecs[v].burst);
      end
      drain(300);
    end
    rr_rand = 0;
    check("max_outstanding", max_out, MO);

    // Mispredict with two blocks in flight; younger follow-up must be ignored.
    lat = 6;
    do_reset(32'h1000);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (fq.size() == MO) got = 1;
    end
    check("two_in_flight", got, 1);
    mispredict(6'd5, 32'h8000);
    mispredict(6'd9, 32'h9000);
    @(negedge clk);
    check("redirect_dec_valid", dec_valid, 0);
    @(posedge clk); #1;
    mispred_valid = 1'b0;
    push_seq(32'h8000, 10);
    drain(300);

    // Older mispredict than the pending one redirects; queued entries vanish.
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("pre_redirect_dec_valid", dec_valid, 1);
    mispredict(6'd3, 32'hA000);
    @(posedge clk); #1;
    mispred_valid = 1'b0;
    @(negedge clk);
    check("older_redirect_flush", dec_valid, 0);
    push_seq(32'hA000, 8);
    drain(300);

    // Nuke: quiet until resume; a mispredict during the nuke supplies the PC.
    lat = 2;
    repeat (15) @(posedge clk);
    #1 nuke_valid = 1'b1;
    @(posedge clk); #1;
    nuke_valid = 1'b0;
    seen_req = 0; seen_dec = 0;
    repeat (10) begin
      @(negedge clk);
      seen_req |= req_valid; seen_dec |= dec_valid;
    end
    check("nuke_no_req", seen_req, 0);
    check("nuke_no_dec", seen_dec, 0);
    mispredict(6'd7, 32'hC004);
    @(posedge clk); #1;
    mispred_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen_req |= req_valid; seen_dec |= dec_valid;
    end
    check("pdg_nuke_no_req", seen_req, 0);
    check("pdg_nuke_no_dec", seen_dec, 0);
    @(posedge clk); #1;
    resume_fetch = 1'b1;
    @(posedge clk); #1;
    resume_fetch = 1'b0;
    push_seq(32'hC004, 9);
    drain(300);

    // Asynchronous reset while the queue holds data.
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pre_reset_dec_valid", dec_valid, 1);
    lat = 3;
    do_reset(32'h5000);
    push_seq(32'h5000, 12);
    drain(300);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fe_fetch_q.md
Name: fe_fetch_q

Overview:
Next-generation front-end fetch controller that decouples fetch from decode with a parametrised instruction queue. It allows up to MAX_OUTSTANDING pipelined fill-buffer requests, each returning a FETCH_W-instruction aligned block. Entries are delivered to decode one per cycle through a valid/ready handshake. It handles branch-mispredict redirects (oldest-wins filtering), pipeline nukes with resume, and epoch-based dropping of stale responses.

Parameters:
FETCH_W, 2, instructions per request block; power of 2, block size FETCH_W*4 bytes
IQ_DEPTH, 8, instruction queue entries; power of 2, >= FETCH_W
MAX_OUTSTANDING, 2, maximum in-flight fill-buffer requests; power of 2
PADDR_W, 32, physical address width
ROBID_W, 6, ROB id width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
boot_pc  in  PADDR_W  PC loaded at reset; sampled while reset is high
nuke_valid  in  1  nuke from retire, front-end flush requested
resume_fetch  in  1  restart fetch after a nuke
oldest_robid  in  ROBID_W  oldest ROB entry, used for age comparison
mispred_valid  in  1  branch mispredict from ex0
mispred_robid  in  ROBID_W  ROB id of the mispredicting branch
mispred_pc  in  PADDR_W  restore PC
req_valid  out  1  fill-buffer request
req_addr  out  PADDR_W  block-aligned request address
req_id  out  $clog2(MAX_OUTSTANDING)  request tag, increments mod MAX_OUTSTANDING
req_ready  in  1  fill buffer accepts request
rsp_valid  in  1  response valid; responses return in request order
rsp_id  in  $clog2(MAX_OUTSTANDING)  echoed tag
rsp_instr  in  32*FETCH_W  instructions, slot 0 at the lowest address
dec_valid  out  1  instruction available to decode
dec_instr  out  32  instruction
dec_pc  out  PADDR_W  instruction PC
dec_ready  in  1  decode accepts

Behaviour:
- Reset (async) clears IQ and in-flight count, sets state IDLE and epoch 0, and loads fetch_pc from boot_pc. req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0.
- States: IDLE -> FETCH unconditionally on the first cycle after reset. FETCH -> PDG_NUKE on nuke_valid. PDG_NUKE -> FETCH on resume_fetch.
- Request rule: req_valid=1 only when all of the following hold:
  - state is FETCH,
  - in-flight < MAX_OUTSTANDING,
  - IQ free entries minus FETCH_W*in-flight >= FETCH_W (credit reservation, so the queue can never overflow),
  - no redirect this cycle.
- Request fields: req_addr = fetch_pc with the low log2(FETCH_W*4) bits cleared. On accept, fetch_pc advances to the next block boundary.
- Each request records {epoch, start slot = fetch_pc[log2(FETCH_W*4)-1:2]} in a MAX_OUTSTANDING tag table.
- Response handling:
  - Every response decrements in-flight.
  - A response whose recorded epoch != current epoch is dropped.
  - Otherwise slots >= start slot are written to the IQ in the same cycle, in order, with pc = block base + 4*slot.
  - rsp_id must equal the expected tag; a mismatch is an assertion.
- Dequeue: dec_valid = IQ non-empty & state != PDG_NUKE. The head pops on dec_valid & dec_ready. Enqueue and dequeue may occur in the same cycle.
- Mispredict qualification: a mispredict qualifies when mispred_valid & (no mispredict pending | mispred_robid older than the pending robid).
  - Age rule: a is older than b iff (a - oldest_robid) mod 2^ROBID_W < (b - oldest_robid) mod 2^ROBID_W.
  - The pending flag sets on a qualified mispredict and clears on nuke.
  - A later, younger mispredict is ignored.
- Redirect (qualified mispredict or nuke_valid):
  - epoch increments (wraps at 2^$clog2(MAX_OUTSTANDING+1)),
  - IQ is flushed next cycle,
  - in-flight requests stay counted and their responses are dropped on return.
  - Mispredict redirect: fetch_pc <= mispred_pc. Nuke: fetch_pc holds until a mispredict supplies a PC.
  - If a nuke and a qualified mispredict occur in the same cycle, fetch_pc takes mispred_pc and state goes to PDG_NUKE.
- Flush vs dequeue: dec_valid=0 in the cycle after a redirect until new data enqueues.
- Pointers: IQ pointers carry an extra wrap bit. Full = same index and different wrap bit.

Test Plan:
- Straight line, FETCH_W=2, boot_pc=0x1000, dec_ready=1 → dec_pc sequence 0x1000, 0x1004, 0x1008, … with no gaps; at most 2 requests outstanding.
- Unaligned boot_pc=0x1004 → first req_addr=0x1000; dec_pc starts at 0x1004, and slot 0 is never delivered.
- Backpressure: dec_ready=0 for 20 cycles → req_valid deasserts once credits < 2; IQ holds 8 entries with no overflow; order is preserved on release.
- Mispredict robid 5 (oldest 2), then robid 9 → fetch restarts at the robid 5 mispred_pc; the second mispredict is ignored. A later robid 3 mispredict → redirect taken.
- Mispredict while 2 requests are in flight → both responses are dropped; the first delivered dec_pc equals mispred_pc.
- nuke_valid → dec_valid=0 and no requests until resume_fetch. Async reset asserted mid-fetch → outputs clear immediately; fetch restarts at boot_pc.
